// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline widths, NOP encoding and the fetch entry type
package mips_pkg;
   localparam int PC_W = 10;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular buffer of {instr, pc} entries with push, pop, flush and count
module ifq_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  mips_pkg::fetch_entry_t   wdata_i,
   output mips_pkg::fetch_entry_t   head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   import mips_pkg::*;
   localparam int AW = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   fetch_entry_t     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   // flush empties the buffer and overrides any same-cycle push or pop
   always_comb begin
      wr_d = flush_i ? '0 : push_i ? wr_q + 1'b1 : wr_q;
      rd_d = flush_i ? '0 : pop_i ? rd_q + 1'b1 : rd_q;
      count_d = flush_i ? '0 : count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end
   // pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         count_q <= count_d;
      end
   end
   // entry storage; contents only matter once counted, so no reset
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end
   assign head_o = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC, in-flight ROM tracker and prefetch queue feeding decode
// Optional IFQ_BYPASS_EN: present returning ROM data straight to decode when the queue is empty.
module inst_fetch_queue #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_W-1:0]        imem_addr,
   input  logic [31:0]            imem_q,
   input  logic                   redirect_valid,
   input  logic [PC_W-1:0]        redirect_pc,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [31:0]            id_instr,
   output logic [PC_W-1:0]        id_pc,
   output logic [$clog2(DEPTH):0] occupancy
);
   import mips_pkg::*;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
   logic             inflight_v_q, inflight_v_d, issue, push, pop;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head, ret;
   // a slot is reserved for every in-flight read, so issue never overfills the queue
   assign issue = (int'(count) + int'(inflight_v_q)) < DEPTH;
   assign ret = '{instr: imem_q, pc: inflight_pc_q};
   // redirect restarts fetch and drops the in-flight read; otherwise issue one word when room
   always_comb begin
      inflight_v_d = !redirect_valid && issue;
      inflight_pc_d = inflight_v_d ? fetch_pc_q : inflight_pc_q;
      fetch_pc_d = redirect_valid ? redirect_pc : issue ? fetch_pc_q + 1'b1 : fetch_pc_q;
   end
   // fetch PC and in-flight tracker registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= '0;
         inflight_pc_q <= '0;
         inflight_v_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_v_q <= inflight_v_d;
      end
   end
`ifdef IFQ_BYPASS_EN
   logic byp;
   assign byp = inflight_v_q && count == '0;
   assign id_valid = count != '0 || inflight_v_q;
   assign id_instr = byp ? imem_q : count != '0 ? head.instr : NOP_INSTR;
   assign id_pc = byp ? inflight_pc_q : count != '0 ? head.pc : '0;
   assign pop = count != '0 && id_ready && !redirect_valid;
   assign push = inflight_v_q && !redirect_valid && !(byp && id_ready);
`else
   assign id_valid = count != '0;
   assign id_instr = id_valid ? head.instr : NOP_INSTR;
   assign id_pc = id_valid ? head.pc : '0;
   assign pop = id_valid && id_ready && !redirect_valid;
   assign push = inflight_v_q && !redirect_valid;
`endif
   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i (ret),
      .head_o  (head),
      .count_o (count)
   );
   assign imem_addr = fetch_pc_q;
   assign occupancy = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenario tests for the fetch queue against a ROM of pc+0x100
module tb_inst_fetch_queue;
   localparam int PC_W = 10;
   localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   logic            clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, id_ready = 1'b0, id_valid;
   logic [PC_W-1:0] redirect_pc = '0, imem_addr, id_pc;
   logic [31:0]     imem_q, id_instr;
   logic [2:0]      occupancy;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) imem_q <= 32'h100 + 32'(imem_addr);
   inst_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_q(imem_q),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .occupancy(occupancy)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      redirect_valid = 1'b0;
      id_ready = rdy;
      tick;
      tick;
      rst = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      id_ready = 1'b0;
      tick;
      tick;
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      total++; if (imem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
      total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %0h want 0", id_instr); end
      total++; if (id_pc !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0h want 0", id_pc); end
   endtask
   task automatic test_stream;
      do_reset(1'b1);
      total++; if (imem_addr !== 10'd0 || id_valid !== 1'b0) begin bad++; $display("FAIL stream_c0: addr %0h valid %b want 0 0", imem_addr, id_valid); end
      for (int c = 1; c <= 12; c++) begin
         tick;
         total++;
         if (c < LAT) begin
            if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_bubble c%0d: valid %b want 0", c, id_valid); end
         end else if (id_valid !== 1'b1 || id_pc !== PC_W'(c - LAT) || id_instr !== 32'h100 + 32'(c - LAT)) begin
            bad++; $display("FAIL stream c%0d: valid %b pc %0h instr %0h want 1 %0h %0h", c, id_valid, id_pc, id_instr, c - LAT, 32'h100 + c - LAT);
         end
      end
   endtask
   task automatic test_stall_and_drain;
      int exp;
      do_reset(1'b0);
      for (int c = 1; c <= 10; c++) begin
         tick;
         total++; if (occupancy > 3'(DEPTH)) begin bad++; $display("FAIL stall_occ c%0d: got %0d want <=%0d", c, occupancy, DEPTH); end
         if (id_valid === 1'b1) begin
            total++; if (id_pc !== 10'd0 || id_instr !== 32'h100) begin bad++; $display("FAIL stall_head c%0d: pc %0h instr %0h want 0 100", c, id_pc, id_instr); end
         end
      end
      total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL stall_full: got %0d want 4", occupancy); end
      total++; if (imem_addr !== 10'd4) begin bad++; $display("FAIL stall_addr: got %0h want 4", imem_addr); end
      id_ready = 1'b1;
      exp = 0;
      for (int c = 0; c < 24; c++) begin
         total++;
         if (id_valid !== 1'b1 || id_pc !== PC_W'(exp) || id_instr !== 32'h100 + 32'(exp) || occupancy > 3'(DEPTH)) begin
            bad++; $display("FAIL drain c%0d: valid %b pc %0h instr %0h occ %0d want 1 %0h %0h <=4", c, id_valid, id_pc, id_instr, occupancy, exp, 32'h100 + exp);
         end
         exp++;
         tick;
      end
   endtask
   task automatic test_redirect;
      do_reset(1'b0);
      repeat (4) tick;
      total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL redir_pre_occ: got %0d want 3", occupancy); end
      redirect_valid = 1'b1;
      redirect_pc = 10'h200;
      id_ready = 1'b1;
      tick;
      redirect_valid = 1'b0;
      total++; if (id_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== 10'h200) begin
         bad++; $display("FAIL redir_t1: valid %b occ %0d addr %0h want 0 0 200", id_valid, occupancy, imem_addr);
      end
      for (int k = 2; k <= 6; k++) begin
         tick;
         total++;
         if (k < 1 + LAT) begin
            if (id_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble t+%0d: valid %b want 0", k, id_valid); end
         end else if (id_valid !== 1'b1 || id_pc !== PC_W'(32'h200 + k - 1 - LAT) || id_instr !== 32'h300 + 32'(k - 1 - LAT)) begin
            bad++; $display("FAIL redir t+%0d: valid %b pc %0h instr %0h want 1 %0h", k, id_valid, id_pc, id_instr, 32'h200 + k - 1 - LAT);
         end
      end
   endtask
   task automatic test_wrap;
      do_reset(1'b1);
      redirect_valid = 1'b1;
      redirect_pc = 10'd1022;
      tick;
      redirect_valid = 1'b0;
      total++; if (id_valid !== 1'b0 || imem_addr !== 10'd1022) begin bad++; $display("FAIL wrap_t1: valid %b addr %0d want 0 1022", id_valid, imem_addr); end
      for (int k = 2; k <= 5 + LAT; k++) begin
         tick;
         if (k >= 1 + LAT) begin
            total++;
            if (id_valid !== 1'b1 || id_pc !== PC_W'(1022 + k - 1 - LAT)) begin
               bad++; $display("FAIL wrap t+%0d: valid %b pc %0d want 1 %0d", k, id_valid, id_pc, (1022 + k - 1 - LAT) % 1024);
            end
         end
      end
   endtask
   task automatic test_mid_reset;
      do_reset(1'b0);
      repeat (8) tick;
      total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL midrst_full: got %0d want 4", occupancy); end
      rst = 1'b1;
      tick;
      total++; if (occupancy !== 3'd0 || id_valid !== 1'b0 || imem_addr !== 10'd0 || id_pc !== 10'd0 || id_instr !== 32'h0) begin
         bad++; $display("FAIL midrst_state: occ %0d valid %b addr %0h pc %0h instr %0h want all 0", occupancy, id_valid, imem_addr, id_pc, id_instr);
      end
      rst = 1'b0;
      id_ready = 1'b1;
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL midrst_c0: valid %b want 0", id_valid); end
      for (int c = 1; c <= LAT + 1; c++) begin
         tick;
         total++;
         if (c < LAT) begin
            if (id_valid !== 1'b0) begin bad++; $display("FAIL midrst_bubble c%0d: valid %b want 0", c, id_valid); end
         end else if (id_valid !== 1'b1 || id_pc !== PC_W'(c - LAT)) begin
            bad++; $display("FAIL midrst_restart c%0d: valid %b pc %0h want 1 %0h", c, id_valid, id_pc, c - LAT);
         end
      end
   endtask
   initial begin
      test_reset;
      test_stream;
      test_stall_and_drain;
      test_redirect;
      test_wrap;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
